student_tlul_arb: RTL and testbench

STUDENT_TLUL_ARB -- requirements
Module: student_tlul_arb

---
 rtl/student_tlul_arb.sv | 163 ++++++++++++++++
 tb/tb_student_tlul_arb.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/student_tlul_arb.sv
// Round-robin arbiter letting NUM TL-UL hosts share one device port, one transaction at a time.
// Also carries the minimal TL-UL struct package the arbiter ports are built from.

package tlul_pkg;
  localparam logic [2:0] PUT_FULL_DATA   = 3'd0;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

// Handshakes: a beat transfers on a rising edge where valid and ready are both high;
// a sender holds valid and payload stable until that edge.
module student_tlul_arb #(
  parameter int NUM = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  tlul_pkg::tl_h2d_t tl_host_i [NUM],
  output tlul_pkg::tl_d2h_t tl_host_o [NUM],
  output tlul_pkg::tl_h2d_t tl_device_o,
  input  tlul_pkg::tl_d2h_t tl_device_i,
  output logic [1:0]        state_o
);
  localparam int IW = (NUM > 1) ? $clog2(NUM) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     pick;
  logic              any_req;
  logic [NUM-1:0]    a_valid_vec;
  logic [NUM-1:0]    rot;
  tlul_pkg::tl_h2d_t own_h2d;

  // Requests rotated so bit i belongs to host (ptr + i) mod NUM.
  always_comb begin
    for (int k = 0; k < NUM; k++) begin
      a_valid_vec[k] = tl_host_i[k].a_valid;
    end
    rot     = NUM'({a_valid_vec, a_valid_vec} >> ptr_q);
    any_req = 1'b0;
    pick    = '0;
    for (int i = 0; i < NUM; i++) begin
      if (!any_req && rot[i]) begin
        any_req = 1'b1;
        pick    = IW'((int'(ptr_q) + i) % NUM);
      end
    end
  end

  always_comb begin
    own_h2d = '0;
    for (int k = 0; k < NUM; k++) begin
      if (owner_q == IW'(k)) begin
        own_h2d = tl_host_i[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          owner_d = pick;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (tl_device_i.a_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (tl_device_i.d_valid && own_h2d.d_ready) begin
          state_d = ST_IDLE;
          ptr_d   = (owner_q == IW'(NUM - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Device a_valid comes from the registered grant, never from a host a_valid;
  // the owner already held a_valid when it was granted and must keep it until a_ready.
  always_comb begin
    tl_device_o = '0;
    for (int k = 0; k < NUM; k++) begin
      tl_host_o[k] = '0;
    end
    case (state_q)
      ST_REQ: begin
        tl_device_o         = own_h2d;
        tl_device_o.a_valid = 1'b1;
        tl_device_o.d_ready = 1'b0;
        for (int k = 0; k < NUM; k++) begin
          if (owner_q == IW'(k)) begin
            tl_host_o[k].a_ready = tl_device_i.a_ready;
          end
        end
      end
      ST_RESP: begin
        tl_device_o.d_ready = own_h2d.d_ready;
        for (int k = 0; k < NUM; k++) begin
          if (owner_q == IW'(k)) begin
            tl_host_o[k]         = tl_device_i;
            tl_host_o[k].a_ready = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_student_tlul_arb.sv
// Directed bench for student_tlul_arb: behavioural register device, expected-response queue and monitor.
module tb_student_tlul_arb;
  import tlul_pkg::*;

  localparam int NUM   = 2;
  localparam int RSP_W = 50;

  logic       clk = 1'b0;
  logic       rst;
  tl_h2d_t    host_h2d [NUM];
  tl_d2h_t    host_d2h [NUM];
  tl_h2d_t    dev_h2d;
  tl_d2h_t    dev_d2h;
  tl_d2h_t    dev_rsp;
  logic       dev_ar_en;
  logic       stray_d;
  logic [1:0] dut_state;
  logic [31:0] mem [16];
  tl_h2d_t    exp_a;

  logic [RSP_W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  student_tlul_arb #(.NUM(NUM)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .tl_host_i   (host_h2d),
    .tl_host_o   (host_d2h),
    .tl_device_o (dev_h2d),
    .tl_device_i (dev_d2h),
    .state_o     (dut_state)
  );

  always_comb begin
    dev_d2h         = dev_rsp;
    dev_d2h.d_valid = dev_rsp.d_valid | stray_d;
    dev_d2h.a_ready = dev_ar_en;
  end

  // ---------------- device model ----------------
  initial begin
    logic    a_hs;
    logic    d_hs;
    tl_h2d_t req;
    dev_rsp = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    forever begin
      @(negedge clk);
      a_hs = dev_h2d.a_valid && dev_d2h.a_ready;
      d_hs = dev_d2h.d_valid && dev_h2d.d_ready;
      req  = dev_h2d;
      @(posedge clk);
      #2;
      if (rst) begin
        dev_rsp = '0;
      end else begin
        if (d_hs) dev_rsp.d_valid = 1'b0;
        if (a_hs) begin
          dev_rsp          = '0;
          dev_rsp.d_valid  = 1'b1;
          dev_rsp.d_size   = req.a_size;
          dev_rsp.d_source = req.a_source;
          if (req.a_opcode == GET) begin
            dev_rsp.d_opcode = ACCESS_ACK_DATA;
            dev_rsp.d_data   = mem[req.a_address[5:2]];
          end else begin
            dev_rsp.d_opcode = ACCESS_ACK;
            mem[req.a_address[5:2]] = req.a_data;
          end
        end
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input int k, input logic [2:0] op, input logic [7:0] src,
                            input logic [31:0] data);
    exp_q.push_back({4'(k), op, 2'd2, src, 1'b0, data});
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [RSP_W-1:0] act;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NUM; k++) begin
        if (host_d2h[k].d_valid && host_h2d[k].d_ready) begin
          act = {4'(k), host_d2h[k].d_opcode, host_d2h[k].d_size, host_d2h[k].d_source,
                 host_d2h[k].d_error, host_d2h[k].d_data};
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL d_rsp_unexpected actual=0x%0h required=none", act);
          end else begin
            check("d_rsp", 128'(act), 128'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_a(input int k);
    logic dr;
    dr = host_h2d[k].d_ready;
    host_h2d[k] = '0;
    host_h2d[k].d_ready = dr;
  endtask

  task automatic set_a(input int k, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [7:0] src);
    host_h2d[k].a_valid   = 1'b1;
    host_h2d[k].a_opcode  = op;
    host_h2d[k].a_param   = 3'd0;
    host_h2d[k].a_size    = 2'd2;
    host_h2d[k].a_source  = src;
    host_h2d[k].a_address = addr;
    host_h2d[k].a_mask    = 4'hf;
    host_h2d[k].a_data    = data;
    host_h2d[k].a_user    = 16'h0;
  endtask

  task automatic host_req(input int k, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] data, input logic [7:0] src);
    bit done;
    done = 1'b0;
    @(posedge clk);
    #1;
    set_a(k, op, addr, data, src);
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (host_d2h[k].a_ready) done = 1'b1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL a_handshake_host%0d actual=timeout required=a_ready", k);
    end
    @(posedge clk);
    #1;
    clear_a(k);
  endtask

  task automatic wait_done(input string name);
    int c;
    c = 0;
    while ((exp_q.size() != 0 || dut_state != 2'd0) && c < 200) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (exp_q.size() != 0 || dut_state != 2'd0) begin
      failures++;
      $display("FAIL %s_done actual=pending%0d_state%0d required=pending0_state0",
               name, exp_q.size(), dut_state);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    for (int k = 0; k < NUM; k++) begin
      host_h2d[k] = '0;
      host_h2d[k].d_ready = 1'b1;
    end
    dev_ar_en = 1'b1;
    stray_d   = 1'b0;
    rst       = 1'b1;
    // Busy inputs while in reset: outputs must still be all zero.
    set_a(0, PUT_FULL_DATA, 32'hdead_beef, 32'hffff_ffff, 8'hff);
    set_a(1, GET, 32'h10, 32'h0, 8'h5a);
    stray_d = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_dev_h2d", 128'(dev_h2d), 128'(0));
    check("rst_host0_d2h", 128'(host_d2h[0]), 128'(0));
    check("rst_host1_d2h", 128'(host_d2h[1]), 128'(0));
    check("rst_state", 128'(dut_state), 128'(0));
    clear_a(0);
    clear_a(1);
    stray_d = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single host: Put 0x4 = 0x5, then Get 0x4.
    expect_rsp(0, ACCESS_ACK, 8'h11, 32'h0);
    host_req(0, PUT_FULL_DATA, 32'h4, 32'h5, 8'h11);
    wait_done("put0");
    expect_rsp(0, ACCESS_ACK_DATA, 8'h12, 32'h5);
    host_req(0, GET, 32'h4, 32'h0, 8'h12);
    wait_done("get0");

    // Host1 alone with ptr=1, leaves ptr wrapped to 0.
    expect_rsp(1, ACCESS_ACK_DATA, 8'h21, 32'h5);
    host_req(1, GET, 32'h4, 32'h0, 8'h21);
    wait_done("get1");

    // Contention, two rounds: host0 first each time.
    expect_rsp(0, ACCESS_ACK_DATA, 8'h31, 32'h5);
    expect_rsp(1, ACCESS_ACK, 8'h32, 32'h0);
    fork
      host_req(0, GET, 32'h4, 32'h0, 8'h31);
      host_req(1, PUT_FULL_DATA, 32'h8, 32'ha5, 8'h32);
    join
    wait_done("contend1");
    expect_rsp(0, ACCESS_ACK_DATA, 8'h41, 32'ha5);
    expect_rsp(1, ACCESS_ACK_DATA, 8'h42, 32'h5);
    fork
      host_req(0, GET, 32'h8, 32'h0, 8'h41);
      host_req(1, GET, 32'h4, 32'h0, 8'h42);
    join
    wait_done("contend2");

    // Back-pressure: device a_ready low for 5 cycles.
    dev_ar_en = 1'b0;
    expect_rsp(0, ACCESS_ACK, 8'h51, 32'h0);
    @(posedge clk);
    #1;
    set_a(0, PUT_FULL_DATA, 32'hc, 32'h1234, 8'h51);
    exp_a = host_h2d[0];
    exp_a.d_ready = 1'b0;
    @(negedge clk);
    check("lat_idle_dev_a_valid", 128'(dev_h2d.a_valid), 128'(0));
    repeat (5) begin
      @(negedge clk);
      check("bp_dev_a_fields", 128'(dev_h2d), 128'(exp_a));
      check("bp_state_req", 128'(dut_state), 128'(1));
      check("bp_host0_a_ready", 128'(host_d2h[0].a_ready), 128'(0));
      check("bp_host1_a_ready", 128'(host_d2h[1].a_ready), 128'(0));
    end
    @(posedge clk);
    #1;
    dev_ar_en = 1'b1;
    @(negedge clk);
    check("bp_release_a_ready", 128'(host_d2h[0].a_ready), 128'(1));
    @(posedge clk);
    #1;
    clear_a(0);
    wait_done("bp");

    // Stalled response: owner d_ready low for 3 cycles.
    host_h2d[0].d_ready = 1'b0;
    expect_rsp(0, ACCESS_ACK_DATA, 8'h61, 32'h1234);
    host_req(0, GET, 32'hc, 32'h0, 8'h61);
    repeat (3) begin
      @(negedge clk);
      check("stall_dev_d_ready", 128'(dev_h2d.d_ready), 128'(0));
      check("stall_host0_d_valid", 128'(host_d2h[0].d_valid), 128'(1));
      check("stall_host0_d_data", 128'(host_d2h[0].d_data), 128'(32'h1234));
      check("stall_state_resp", 128'(dut_state), 128'(2));
    end
    @(posedge clk);
    #1;
    host_h2d[0].d_ready = 1'b1;
    wait_done("stall");

    // Reset in RESP: transaction abandoned, ptr back to 0.
    host_h2d[0].d_ready = 1'b0;
    host_req(0, GET, 32'h4, 32'h0, 8'h71);
    @(negedge clk);
    check("rm_state_resp", 128'(dut_state), 128'(2));
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("rm_dev_h2d", 128'(dev_h2d), 128'(0));
    check("rm_host0_d2h", 128'(host_d2h[0]), 128'(0));
    check("rm_host1_d2h", 128'(host_d2h[1]), 128'(0));
    check("rm_state", 128'(dut_state), 128'(0));
    host_h2d[0].d_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_rsp(0, ACCESS_ACK_DATA, 8'h81, 32'h5);
    expect_rsp(1, ACCESS_ACK_DATA, 8'h82, 32'ha5);
    fork
      host_req(0, GET, 32'h4, 32'h0, 8'h81);
      host_req(1, GET, 32'h8, 32'h0, 8'h82);
    join
    wait_done("post_rst_pair");
    expect_rsp(1, ACCESS_ACK_DATA, 8'h91, 32'h1234);
    host_req(1, GET, 32'hc, 32'h0, 8'h91);
    wait_done("post_rst_host1");

    // Stray device D in IDLE.
    @(posedge clk);
    #1;
    stray_d = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stray_host0_d2h", 128'(host_d2h[0]), 128'(0));
      check("stray_host1_d2h", 128'(host_d2h[1]), 128'(0));
      check("stray_dev_d_ready", 128'(dev_h2d.d_ready), 128'(0));
      check("stray_state_idle", 128'(dut_state), 128'(0));
    end
    @(posedge clk);
    #1;
    stray_d = 1'b0;
    repeat (3) @(negedge clk);

    check("exp_q_empty", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
